// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Access-type codes are packed two bits per register in the bank's ACC_TYPE parameter.
package regfile_pkg;

  typedef enum logic [1:0] {
    ACC_RW  = 2'b00,
    ACC_RO  = 2'b01,
    ACC_W1C = 2'b10,
    ACC_WOC = 2'b11
  } acc_type_e;

  localparam int MAX_REGS = 64;

  // Unsigned offset of a host address from the bank base. An address below
  // the base wraps to a huge value, so callers must also check addr >= base.
  function automatic logic [31:0] reg_idx(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/regfile_param_bank_if.sv
// Host-side register access bus: one-cycle read/write strobes, registered read return.
interface regfile_param_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) ();

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              rd_valid;
  logic              addr_err;

  modport master (
    output wr_en, rd_en, addr, write_data,
    input  read_data, rd_valid, addr_err
  );

  modport slave (
    input  wr_en, rd_en, addr, write_data,
    output read_data, rd_valid, addr_err
  );

endinterface

// File: rtl/regfile_reg_cell.sv
// Storage and update rule for one register of the bank, selected by its access type.
// Also drives this register's command strobe slice and its read-mux contribution.
module regfile_reg_cell
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter acc_type_e         ACC       = ACC_RW,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_hit,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] hw_status,
  input  logic [DATA_W-1:0] hw_set,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] rd_value,
  output logic [DATA_W-1:0] cmd_pulse
);

  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] pulse_q, pulse_d;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    store_d = store_q;
    pulse_d = '0;
    case (ACC)
      ACC_RW:  if (wr_hit) store_d = write_data;
      // Set is OR-ed in last so it wins over a same-cycle clear.
      ACC_W1C: store_d = (store_q & ~(wr_hit ? write_data : '0)) | hw_set;
      ACC_WOC: if (wr_hit) pulse_d = write_data;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= RESET_VAL;
      pulse_q <= '0;
    end else begin
      store_q <= store_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    q        = '0;
    rd_value = '0;
    case (ACC)
      ACC_RW, ACC_W1C: begin
        q        = store_q;
        rd_value = store_q;
      end
      ACC_RO:  rd_value = hw_status;
      default: ;
    endcase
  end

  assign cmd_pulse = pulse_q;

endmodule

// File: rtl/regfile_param_bank.sv
// Parametrised control/status register bank: address decode, registered read,
// out-of-range error pulse and W1C event interrupt; per-register state lives in regfile_reg_cell.
module regfile_param_bank
  import regfile_pkg::*;
#(
  parameter int                         NUM_REGS  = 8,
  parameter int                         DATA_W    = 16,
  parameter int                         ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]          BASE_ADDR = ADDR_W'(1),
  parameter logic [2*NUM_REGS-1:0]      ACC_TYPE  = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_param_bank_if.slave          bus,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   cmd_pulse,
  output logic                         irq
);

  logic [31:0]                idx;
  logic                       hit;
  logic [NUM_REGS-1:0]        wr_hit;
  logic [NUM_REGS*DATA_W-1:0] rd_vals;
  logic [DATA_W-1:0]          rd_mux;
  logic                       w1c_any;

  logic [DATA_W-1:0]          read_data_q;
  logic                       rd_valid_q;
  logic                       addr_err_q;
  logic                       irq_q;

  // Both bounds are needed: an address below the base wraps idx to a large value.
  assign idx = reg_idx(32'(bus.addr), 32'(BASE_ADDR));
  assign hit = (bus.addr >= BASE_ADDR) && (idx < 32'(NUM_REGS));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign wr_hit[g] = bus.wr_en && hit && (idx == 32'(g));

    regfile_reg_cell #(
      .DATA_W    (DATA_W),
      .ACC       (acc_type_e'(ACC_TYPE[2*g +: 2])),
      .RESET_VAL (RESET_VAL[DATA_W*g +: DATA_W])
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_hit     (wr_hit[g]),
      .write_data (bus.write_data),
      .hw_status  (hw_status[DATA_W*g +: DATA_W]),
      .hw_set     (hw_set[DATA_W*g +: DATA_W]),
      .q          (reg_q[DATA_W*g +: DATA_W]),
      .rd_value   (rd_vals[DATA_W*g +: DATA_W]),
      .cmd_pulse  (cmd_pulse[DATA_W*g +: DATA_W])
    );
  end

  // Mux reads the cells' current outputs, so a same-cycle write is not yet visible.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 32'(i)) rd_mux = rd_vals[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    w1c_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (acc_type_e'(ACC_TYPE[2*i +: 2]) == ACC_W1C)
        w1c_any = w1c_any | (|reg_q[DATA_W*i +: DATA_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      read_data_q <= (bus.rd_en && hit) ? rd_mux : '0;
      rd_valid_q  <= bus.rd_en;
      addr_err_q  <= (bus.wr_en || bus.rd_en) && !hit;
      irq_q       <= w1c_any;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.addr_err  = addr_err_q;
  assign irq           = irq_q;

endmodule
